// File: rtl/sram_subsys_pkg.sv
// Shared AHB encodings, response-FSM states and size helpers for the SRAM subsystem.
package sram_subsys_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  localparam logic [2:0] HSIZE_4WORD = 3'd4;
  localparam logic [2:0] HSIZE_8WORD = 3'd5;
  localparam logic [2:0] HSIZE_512   = 3'd6;
  localparam logic [2:0] HSIZE_1024  = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    StReady = 2'd0,
    StStall = 2'd1,
    StErr1  = 2'd2,
    StErr2  = 2'd3
  } resp_state_e;

  // Largest hsize whose byte count fits in data_width bits.
  function automatic logic [2:0] max_hsize(input int unsigned data_width);
    logic [2:0] r;
    r = HSIZE_BYTE;
    for (int i = 0; i < 8; i++) begin
      if ((32'd8 << i) <= data_width) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_access_decode.sv
// Address-phase decode: qualification, size/alignment checks and group select.
module sram_access_decode
  import sram_subsys_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned GROUP_LSB  = 12
) (
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hready_in,
  input  logic [NUM_GROUPS-1:0] rw_conflict,
  output logic                  accept,
  output logic                  size_err,
  output logic                  align_err,
  output logic [NUM_GROUPS-1:0] group_onehot,
  output logic                  conflict
);

  localparam int unsigned GroupW   = $clog2(NUM_GROUPS);
  localparam logic [2:0]  MaxHsize = max_hsize(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] align_mask;
  logic [GroupW-1:0]     group_idx;

  assign accept    = hsel & htrans[1] & hready_in;
  assign size_err  = hsize > MaxHsize;
  assign group_idx = haddr[GROUP_LSB +: GroupW];
  assign conflict  = rw_conflict[group_idx];

  // Low address bits that must be zero for the requested transfer size.
  always_comb begin
    align_mask = '0;
    for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
      align_mask[i] = (i < int'(hsize));
    end
  end

  // Alignment is only meaningful for sizes the bus can carry.
  assign align_err = ~size_err & (|(haddr & align_mask));

  always_comb begin
    group_onehot            = '0;
    group_onehot[group_idx] = 1'b1;
  end

endmodule

// File: rtl/sram_ahb_resp_gen.sv
// AHB slave response generator: wait states, per-group conflict stalls and
// two-cycle ERROR responses with a saturating error counter.
module sram_ahb_resp_gen
  import sram_subsys_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_GROUPS  = 4,
  parameter int unsigned GROUP_LSB   = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic                  hready_in,
  input  logic [NUM_GROUPS-1:0] rw_conflict,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic                  valid_access,
  output logic [NUM_GROUPS-1:0] access_group,
  output logic [ERR_CNT_W-1:0]  err_count
);

  logic                  accept;
  logic                  size_err;
  logic                  align_err;
  logic [NUM_GROUPS-1:0] group_onehot;
  logic                  conflict;
  logic                  access_err;
  logic [4:0]            stall_n;
  resp_state_e           state_q;
  logic [4:0]            cnt_q;

  sram_access_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_GROUPS (NUM_GROUPS),
    .GROUP_LSB  (GROUP_LSB)
  ) u_decode (
    .hsel         (hsel),
    .htrans       (htrans),
    .hsize        (hsize),
    .haddr        (haddr),
    .hready_in    (hready_in),
    .rw_conflict  (rw_conflict),
    .accept       (accept),
    .size_err     (size_err),
    .align_err    (align_err),
    .group_onehot (group_onehot),
    .conflict     (conflict)
  );

  assign access_err   = accept & (size_err | align_err);
  assign valid_access = accept & ~size_err & ~align_err;
  assign access_group = valid_access ? group_onehot : '0;

  // Writes never wait on a conflicting write data phase.
  assign stall_n = 5'(WAIT_STATES) + 5'(~hwrite & conflict);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= StReady;
      cnt_q     <= '0;
      hready    <= 1'b1;
      hresp     <= HRESP_OKAY;
      err_count <= '0;
    end else begin
      case (state_q)
        StReady, StErr2: begin
          if (access_err) begin
            state_q <= StErr1;
            hready  <= 1'b0;
            hresp   <= HRESP_ERROR;
            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
          end else if (valid_access && (stall_n != 5'd0)) begin
            state_q <= StStall;
            cnt_q   <= stall_n;
            hready  <= 1'b0;
            hresp   <= HRESP_OKAY;
          end else begin
            state_q <= StReady;
            hready  <= 1'b1;
            hresp   <= HRESP_OKAY;
          end
        end
        StStall: begin
          if (cnt_q == 5'd1) begin
            state_q <= StReady;
            cnt_q   <= '0;
            hready  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
          hresp <= HRESP_OKAY;
        end
        StErr1: begin
          state_q <= StErr2;
          hready  <= 1'b1;
          hresp   <= HRESP_ERROR;
        end
        default: begin
          state_q <= StReady;
          cnt_q   <= '0;
          hready  <= 1'b1;
          hresp   <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule
